// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : RV32IM fetch stage. Holds the PC, issues instruction-memory
//               reads under a busy-wait handshake and drives the IF/ID
//               register. Optional perf counters: define IF_PERF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        VALID
`ifdef IF_PERF_COUNT_EN
    ,
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] BUBBLE_COUNT
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] c_WORD_BYTES = 32'd4;

    state_t      state_q,      state_d;
    logic [31:0] pc_reg_q,     pc_reg_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] pc_plus4_q,   pc_plus4_d;
    logic        valid_q,      valid_d;

    logic        w_done;
    logic [31:0] w_target;

`ifdef IF_PERF_COUNT_EN
    logic        w_load_valid;
    logic        w_load_bubble;
    logic [31:0] fetch_count_q,  fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;
`endif

    // Memory request is decoded from state only; RESET gates it so the
    // request stays quiet for as long as the memory is held in reset too.
    assign IMEM_READ    = RESET && (state_q != S_HOLD);
    assign IMEM_ADDRESS = !RESET              ? RESET_PC     :
                          (state_q == S_DRAIN) ? drain_addr_q : pc_reg_q;

    assign w_done   = IMEM_READ && !IMEM_BUSYWAIT;
    assign w_target = BRANCH_TARGET & ~32'h0000_0003;

    always_comb begin
        state_d      = state_q;
        pc_reg_d     = pc_reg_q;
        drain_addr_d = drain_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q;
`ifdef IF_PERF_COUNT_EN
        w_load_valid  = 1'b0;
        w_load_bubble = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                if (BRANCH_TAKEN) begin
                    instr_d      = BUBBLE;
                    valid_d      = 1'b0;
                    skid_instr_d = 32'h0;
                    skid_pc_d    = 32'h0;
                    pc_reg_d     = w_target;
`ifdef IF_PERF_COUNT_EN
                    w_load_bubble = 1'b1;
`endif
                    // The read in flight cannot be aborted; wait it out.
                    if (!w_done) begin
                        state_d      = S_DRAIN;
                        drain_addr_d = pc_reg_q;
                    end
                end else if (w_done) begin
                    pc_reg_d = pc_reg_q + c_WORD_BYTES;
                    if (!STALL) begin
                        instr_d    = IMEM_READDATA;
                        pc_d       = pc_reg_q;
                        pc_plus4_d = pc_reg_q + c_WORD_BYTES;
                        valid_d    = 1'b1;
`ifdef IF_PERF_COUNT_EN
                        w_load_valid = 1'b1;
`endif
                    end else begin
                        skid_instr_d = IMEM_READDATA;
                        skid_pc_d    = pc_reg_q;
                        state_d      = S_HOLD;
                    end
                end else if (!STALL) begin
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
`ifdef IF_PERF_COUNT_EN
                    w_load_bubble = 1'b1;
`endif
                end
            end

            S_HOLD: begin
                if (BRANCH_TAKEN) begin
                    instr_d      = BUBBLE;
                    valid_d      = 1'b0;
                    skid_instr_d = 32'h0;
                    skid_pc_d    = 32'h0;
                    pc_reg_d     = w_target;
                    state_d      = S_FETCH;
`ifdef IF_PERF_COUNT_EN
                    w_load_bubble = 1'b1;
`endif
                end else if (!STALL) begin
                    instr_d    = skid_instr_q;
                    pc_d       = skid_pc_q;
                    pc_plus4_d = skid_pc_q + c_WORD_BYTES;
                    valid_d    = 1'b1;
                    state_d    = S_FETCH;
`ifdef IF_PERF_COUNT_EN
                    w_load_valid = 1'b1;
`endif
                end
            end

            S_DRAIN: begin
                if (BRANCH_TAKEN) begin
                    pc_reg_d = w_target;
                end else if (w_done) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

`ifdef IF_PERF_COUNT_EN
    always_comb begin
        fetch_count_d  = fetch_count_q  + {31'h0, w_load_valid};
        bubble_count_d = bubble_count_q + {31'h0, w_load_bubble};
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            fetch_count_q  <= 32'h0;
            bubble_count_q <= 32'h0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign FETCH_COUNT  = fetch_count_q;
    assign BUBBLE_COUNT = bubble_count_q;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= S_FETCH;
            pc_reg_q     <= RESET_PC;
            drain_addr_q <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            instr_q      <= BUBBLE;
            pc_q         <= 32'h0;
            pc_plus4_q   <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_reg_q     <= pc_reg_d;
            drain_addr_q <= drain_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign PC          = pc_q;
    assign PC_PLUS4    = pc_plus4_q;
    assign VALID       = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed scoreboard bench for instruction_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    localparam logic [31:0] c_W0    = 32'h0130_8433;
    localparam logic [31:0] c_W4    = 32'h0000_0513;
    localparam logic [31:0] c_W8    = 32'h00A0_0093;
    localparam logic [31:0] c_WC    = 32'h0010_8113;
    localparam logic [31:0] c_W10   = 32'h0021_0193;
    localparam logic [31:0] c_W14   = 32'h0031_8213;
    localparam logic [31:0] c_W100  = 32'h0042_0293;
    localparam logic [31:0] c_W104  = 32'h0052_8313;
    localparam logic [31:0] c_WTOP  = 32'h0063_8393;

    logic        CLK;
    logic        RESET;
    logic [31:0] IMEM_ADDRESS;
    logic        IMEM_READ;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        VALID;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] FETCH_COUNT;
    logic [31:0] BUBBLE_COUNT;
`endif

    instruction_fetch_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IMEM_ADDRESS  (IMEM_ADDRESS),
        .IMEM_READ     (IMEM_READ),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .INSTRUCTION   (INSTRUCTION),
        .PC            (PC),
        .PC_PLUS4      (PC_PLUS4),
        .VALID         (VALID)
`ifdef IF_PERF_COUNT_EN
        ,
        .FETCH_COUNT   (FETCH_COUNT),
        .BUBBLE_COUNT  (BUBBLE_COUNT)
`endif
    );

    typedef struct packed {
        logic [7:0]  id;
        logic        read;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] step_id  = 8'd0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = c_W0;
            32'h0000_0004: mem_word = c_W4;
            32'h0000_0008: mem_word = c_W8;
            32'h0000_000C: mem_word = c_WC;
            32'h0000_0010: mem_word = c_W10;
            32'h0000_0014: mem_word = c_W14;
            32'h0000_0100: mem_word = c_W100;
            32'h0000_0104: mem_word = c_W104;
            32'hFFFF_FFFC: mem_word = c_WTOP;
            default:       mem_word = {16'hDEAD, a[15:0]};
        endcase
    endfunction

    always_comb IMEM_READDATA = mem_word(IMEM_ADDRESS);

    task automatic chk(input string name, input logic [7:0] id,
                       input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, expv);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_read", e.id, {31'h0, IMEM_READ}, {31'h0, e.read});
            if (e.read)
                chk("imem_address", e.id, IMEM_ADDRESS, e.addr);
            chk("instruction", e.id, INSTRUCTION, e.instr);
            chk("pc", e.id, PC, e.pc);
            chk("pc_plus4", e.id, PC_PLUS4, e.pc4);
            chk("valid", e.id, {31'h0, VALID}, {31'h0, e.valid});
        end
    end

    task automatic step(input logic rst, input logic busy, input logic stall,
                        input logic br, input logic [31:0] tgt,
                        input logic e_read, input logic [31:0] e_addr,
                        input logic [31:0] e_instr, input logic [31:0] e_pc,
                        input logic [31:0] e_pc4, input logic e_valid);
        exp_t e;
        RESET         = rst;
        IMEM_BUSYWAIT = busy;
        STALL         = stall;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        e = '{id: step_id, read: e_read, addr: e_addr, instr: e_instr,
              pc: e_pc, pc4: e_pc4, valid: e_valid};
        exp_q.push_back(e);
        step_id = step_id + 8'd1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET         = 1'b0;
        IMEM_BUSYWAIT = 1'b1;
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
        @(posedge CLK);
        #1;
        //   rst busy stl br  target        rd   addr          instr   pc            pc4           v
        // reset held while memory is busy
        step(0, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,  32'h0,        32'h0,        0);
        step(0, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,  32'h0,        32'h0,        0);
        // zero-wait stream
        step(1, 0, 0, 0, 32'h0,          1, 32'h0,          32'h0,  32'h0,        32'h0,        0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h4,          c_W0,   32'h0,        32'h4,        1);
        // three busy cycles at address 8
        step(1, 1, 0, 0, 32'h0,          1, 32'h8,          c_W4,   32'h4,        32'h8,        1);
        step(1, 1, 0, 0, 32'h0,          1, 32'h8,          32'h0,  32'h4,        32'h8,        0);
        step(1, 1, 0, 0, 32'h0,          1, 32'h8,          32'h0,  32'h4,        32'h8,        0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h8,          32'h0,  32'h4,        32'h8,        0);
        // stall spanning the completion at 0xC
        step(1, 0, 1, 0, 32'h0,          1, 32'hC,          c_W8,   32'h8,        32'hC,        1);
        step(1, 0, 1, 0, 32'h0,          0, 32'h0,          c_W8,   32'h8,        32'hC,        1);
        step(1, 0, 0, 0, 32'h0,          0, 32'h0,          c_W8,   32'h8,        32'hC,        1);
        step(1, 0, 0, 0, 32'h0,          1, 32'h10,         c_WC,   32'hC,        32'h10,       1);
        // redirect to 0x101 while 0x14 is busy, stall asserted alongside
        step(1, 1, 1, 1, 32'h101,        1, 32'h14,         c_W10,  32'h10,       32'h14,       1);
        step(1, 1, 0, 0, 32'h0,          1, 32'h14,         32'h0,  32'h10,       32'h14,       0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h14,         32'h0,  32'h10,       32'h14,       0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h100,        32'h0,  32'h10,       32'h14,       0);
        // redirect on a completing fetch, to the top of the address space
        step(1, 0, 0, 1, 32'hFFFF_FFFE,  1, 32'h104,        c_W100, 32'h100,      32'h104,      1);
        step(1, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  32'h0,  32'h100,      32'h104,      0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h0,          c_WTOP, 32'hFFFF_FFFC, 32'h0,       1);
        // redirect out of the skid-hold state
        step(1, 0, 1, 0, 32'h0,          1, 32'h4,          c_W0,   32'h0,        32'h4,        1);
        step(1, 0, 1, 1, 32'h104,        0, 32'h0,          c_W0,   32'h0,        32'h4,        1);
        step(1, 0, 0, 0, 32'h0,          1, 32'h104,        32'h0,  32'h0,        32'h4,        0);
        // busy with stall leaves IF/ID alone, then reset mid-wait
        step(1, 1, 1, 0, 32'h0,          1, 32'h108,        c_W104, 32'h104,      32'h108,      1);
        step(0, 1, 0, 0, 32'h0,          0, 32'h0,          c_W104, 32'h104,      32'h108,      1);
        step(0, 1, 0, 0, 32'h0,          0, 32'h0,          32'h0,  32'h0,        32'h0,        0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h0,          32'h0,  32'h0,        32'h0,        0);
        step(1, 0, 0, 0, 32'h0,          1, 32'h4,          c_W0,   32'h0,        32'h4,        1);

        repeat (2) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
